// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: sample/status bundle between a pattern source and lfsr_checker.
//   din        generator word under test
//   din_valid  din carries a new sample this cycle
//   clr_cnt    synchronous clear of err_count and lockup
//   locked     checker is synchronised to the sequence
//   error      one-cycle pulse on a locked mismatch
//   err_count  saturating count of locked mismatches
//   lockup     sticky all-ones sample flag
// master = the side driving samples, slave = the checker.
interface lfsr_checker_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic             lockup;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, error, err_count, lockup
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, error, err_count, lockup
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side monitor for an XNOR-feedback shift-register generator.
// Self-synchronises on the sampled word stream, then predicts each following word
// and counts mismatches. Also flags the all-ones XNOR lockup word.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  lfsr_checker_if.slave (din, din_valid, clr_cnt in; locked, error,
//        err_count, lockup out). All outputs are registered, 1-cycle latency.
module lfsr_checker #(
    parameter int               WIDTH      = 2,
    parameter logic [WIDTH-1:0] TAPS       = 2'b11,
    parameter int               LOCK_COUNT = 4,
    parameter int               MISS_LIMIT = 3,
    parameter int               CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);
    typedef enum logic {ACQUIRE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       miss_q, miss_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] expected;
    logic             all_ones;
    logic             match;
    logic [7:0]       run_inc;
    logic [7:0]       miss_inc;

    assign expected = {prev_q[WIDTH-2:0], ~^(prev_q & TAPS)};
    assign all_ones = &bus.din;
    assign match    = (bus.din == expected);
    assign run_inc  = run_q + 8'd1;
    assign miss_inc = miss_q + 8'd1;

    // State register plus all datapath/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACQUIRE;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            miss_q      <= '0;
            error_q     <= 1'b0;
            cnt_q       <= '0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            error_q     <= error_d;
            cnt_q       <= cnt_d;
            lockup_q    <= lockup_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.din_valid && have_prev_q) begin
            case (state_q)
                ACQUIRE: if (match && !all_ones && run_inc == 8'(LOCK_COUNT)) state_d = LOCKED;
                LOCKED:  if (!match && miss_inc == 8'(MISS_LIMIT))            state_d = ACQUIRE;
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        error_d     = 1'b0;
        cnt_d       = cnt_q;
        lockup_d    = lockup_q;
        if (bus.din_valid) begin
            if (all_ones) lockup_d = 1'b1;
            if (!have_prev_q) begin
                // Seed the predictor; nothing to compare against yet
                prev_d      = bus.din;
                have_prev_d = 1'b1;
            end else begin
                case (state_q)
                    ACQUIRE: begin
                        prev_d = bus.din;
                        // all-ones satisfies its own prediction, so it never counts
                        if (match && !all_ones) begin
                            run_d = run_inc;
                            if (run_inc == 8'(LOCK_COUNT)) miss_d = '0;
                        end else begin
                            run_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_d = '0;
                            prev_d = bus.din;
                        end else begin
                            error_d = 1'b1;
                            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                            miss_d = miss_inc;
                            // Flywheel on the prediction so one bad word costs one error
                            prev_d = expected;
                            if (miss_inc == 8'(MISS_LIMIT)) begin
                                run_d       = '0;
                                have_prev_d = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (bus.clr_cnt) begin
            cnt_d    = '0;
            lockup_d = 1'b0;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.error     = error_q;
    assign bus.err_count = cnt_q;
    assign bus.lockup    = lockup_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker (WIDTH=2, TAPS=11,
// LOCK_COUNT=4, MISS_LIMIT=3). Each sample pushes its hand-derived expected
// outputs; a monitor pops them one cycle after the sampling edge.
module tb_lfsr_checker;
    logic clk;
    logic rst;

    lfsr_checker_if #(.WIDTH(2), .CNT_W(16)) bus ();

    lfsr_checker #(
        .WIDTH(2), .TAPS(2'b11), .LOCK_COUNT(4), .MISS_LIMIT(3), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        locked;
        logic        error;
        logic [15:0] cnt;
        logic        lockup;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_vec  = 0;
    int   n_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".locked"}, 32'(bus.locked),    32'(e.locked));
        chk({tag, ".error"},  32'(bus.error),     32'(e.error));
        chk({tag, ".cnt"},    32'(bus.err_count), 32'(e.cnt));
        chk({tag, ".lockup"}, 32'(bus.lockup),    32'(e.lockup));
    endtask

    // Monitor: compare one cycle after each sampled valid word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (bus.din_valid && !rst) begin
                #1;
                chk("sb_size", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_all("sample", e);
                end
            end
        end
    end

    task automatic send(input logic [1:0] d, input logic c,
                        input logic el, input logic ee, input int ec, input logic elk);
        exp_t e;
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = 1'b1;
        bus.clr_cnt   = c;
        e.locked = el; e.error = ee; e.cnt = 16'(ec); e.lockup = elk;
        sb.push_back(e);
        last_exp = e;
    endtask

    // Idle cycles: outputs must hold; error only persists for its one cycle
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.clr_cnt   = 1'b0;
            chk_all("hold", last_exp);
            last_exp.error = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_exp = '{1'b0, 1'b0, 16'd0, 1'b0};
        chk_all("reset", last_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.clr_cnt = 1'b0;
        last_exp = '{1'b0, 1'b0, 16'd0, 1'b0};
        repeat (2) @(negedge clk);
        chk_all("rst_held", last_exp);
        do_reset();

        // 1: acquire on 00,01,10,00,01
        send(2'b00, 0, 0, 0, 0, 0);
        send(2'b01, 0, 0, 0, 0, 0);
        send(2'b10, 0, 0, 0, 0, 0);
        send(2'b00, 0, 0, 0, 0, 0);
        send(2'b01, 0, 1, 0, 0, 0);
        // 2: expected 10, corrupt to 11, then 00 matches through the flywheel
        send(2'b11, 0, 1, 1, 1, 1);
        send(2'b00, 0, 1, 0, 1, 1);
        // clear counter and lockup while idle
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b1;
        @(negedge clk);
        bus.clr_cnt   = 1'b0;
        last_exp = '{1'b1, 1'b0, 16'd0, 1'b0};
        chk_all("clr", last_exp);
        // 3: three misses (expected 01,10,00) drop lock, then 5 good samples relock
        send(2'b10, 0, 1, 1, 1, 0);
        send(2'b01, 0, 1, 1, 2, 0);
        send(2'b01, 0, 0, 1, 3, 0);
        send(2'b00, 0, 0, 0, 3, 0);
        send(2'b01, 0, 0, 0, 3, 0);
        send(2'b10, 0, 0, 0, 3, 0);
        send(2'b00, 0, 0, 0, 3, 0);
        send(2'b01, 0, 1, 0, 3, 0);
        idle(2);

        // 4: constant all-ones never locks, sets lockup
        do_reset();
        for (int i = 0; i < 10; i++) send(2'b11, 0, 0, 0, 0, 1);
        idle(1);

        // 5: acquire with 2-cycle gaps
        do_reset();
        send(2'b00, 0, 0, 0, 0, 0); idle(2);
        send(2'b01, 0, 0, 0, 0, 0); idle(2);
        send(2'b10, 0, 0, 0, 0, 0); idle(2);
        send(2'b00, 0, 0, 0, 0, 0); idle(2);
        send(2'b01, 0, 1, 0, 0, 0); idle(2);

        // 6: locked, then asynchronous reset mid-cycle
        send(2'b10, 0, 1, 0, 0, 0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        last_exp = '{1'b0, 1'b0, 16'd0, 1'b0};
        chk_all("async_rst", last_exp);
        @(negedge clk);
        rst = 1'b0;
        send(2'b00, 0, 0, 0, 0, 0);
        send(2'b01, 0, 0, 0, 0, 0);
        send(2'b10, 0, 0, 0, 0, 0);
        send(2'b00, 0, 0, 0, 0, 0);
        send(2'b01, 0, 1, 0, 0, 0);
        // clr_cnt together with a mismatch on an all-ones word: pulse, but cnt/lockup clear
        send(2'b11, 1, 1, 1, 0, 0);
        idle(2);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
